mux_n_reg: RTL and testbench

- Parametrised, registered N:1 word multiplexer with optional output inversion; successor to the single-bit inverting 2:1 mux cell.
- Data moves on valid/ready handshakes per input channel.
- Select changes use a request/drain/switch sequence, so no word is ever steered from a stale select.
- Used in the AES datapath to pick round-key, state or bypass words into the next pipeline stage.

---
 rtl/mux_n_pkg.sv | 7 +
 rtl/mux_n_out_reg.sv | 26 ++
 rtl/mux_n_reg.sv | 60 ++++++
 tb/tb_mux_n_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mux_n_pkg.sv
// mux_n_pkg: shared types and helpers for the registered N:1 word multiplexer
package mux_n_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, SWITCH} sel_state_t;
  function automatic int sel_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_n_out_reg.sv
// mux_n_out_reg: one-entry valid/ready holding register with optional inversion at load
module mux_n_out_reg #(
  parameter int WIDTH  = 8,
  parameter bit INVERT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             space
);
  assign space = !valid || ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= INVERT ? ~load_data : load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/mux_n_reg.sv
// mux_n_reg: registered N:1 word mux with handshaked inputs and drain-before-switch select changes
module mux_n_reg import mux_n_pkg::*; #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 4,
  parameter  int INVERT = 1,
  localparam int SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    sel_load,
  input  logic [SEL_W-1:0]        sel_value,
  output logic [SEL_W-1:0]        sel_cur,
  output logic                    sel_busy,
  output logic                    sel_err
);
  sel_state_t       state, state_nxt;
  logic [SEL_W-1:0] pending;
  logic [WIDTH-1:0] word;
  logic             space, accept, sel_ok, start;
  assign word     = in_data[sel_cur*WIDTH +: WIDTH];
  assign in_ready = (!rst && state == RUN && space) ? NUM_IN'(1) << sel_cur : '0;
  assign accept   = in_valid[sel_cur] & in_ready[sel_cur];
  assign sel_ok   = int'(sel_value) < NUM_IN;
  assign start    = state == RUN && sel_load && sel_ok && sel_value != sel_cur;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else     state <= state_nxt;
  // Switching waits until the held word has left, so nothing is steered from a stale select
  always_comb
    state_nxt = (state == RUN)   ? (start ? DRAIN : RUN) :
                (state == DRAIN) ? (space ? SWITCH : DRAIN) : RUN;
  always_comb
    sel_busy = state != RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      sel_cur <= '0;
      sel_err <= 1'b0;
    end else begin
      sel_err <= sel_load && (state != RUN || !sel_ok);
      if (start) pending <= sel_value;
      if (state == SWITCH) sel_cur <= pending;
    end
  mux_n_out_reg #(.WIDTH(WIDTH), .INVERT(INVERT != 0)) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_data(word),
    .data     (out_data),
    .valid    (out_valid),
    .ready    (out_ready),
    .space    (space)
  );
endmodule

// File: tb/tb_mux_n_reg.sv
// tb_mux_n_reg: directed and randomized scoreboard bench for mux_n_reg
module tb_mux_n_reg;
  logic        clk = 0, rst = 1;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready = 0, sel_load = 0, sel_busy, sel_err;
  logic [1:0]  sel_value = '0, sel_cur;
  logic [23:0] in_data_b = '0;
  logic [2:0]  in_valid_b = '0, in_ready_b;
  logic [7:0]  out_data_b;
  logic        out_valid_b, out_ready_b = 0, sel_load_b = 0, sel_busy_b, sel_err_b;
  logic [1:0]  sel_value_b = '0, sel_cur_b;
  int tests = 0, fails = 0;
  int m_phase, m_sel, m_pend;
  bit m_full, m_err, acc;
  logic [3:0] er;
  logic [7:0] q[$];
  logic [7:0] exp_w;

  always #5 clk = ~clk;

  mux_n_reg dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_load(sel_load), .sel_value(sel_value), .sel_cur(sel_cur),
    .sel_busy(sel_busy), .sel_err(sel_err));

  mux_n_reg #(.WIDTH(8), .NUM_IN(3), .INVERT(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .sel_load(sel_load_b), .sel_value(sel_value_b), .sel_cur(sel_cur_b),
    .sel_busy(sel_busy_b), .sel_err(sel_err_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle-level reference of the select protocol; pushes the expected word for every accept
  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0; m_sel = 0; m_pend = 0; m_full = 0; m_err = 0;
      q.delete();
    end else begin
      er = (m_phase == 0 && (!m_full || out_ready)) ? 4'(1 << m_sel) : 4'b0;
      chk("m_in_ready", in_ready, er);
      chk("m_out_valid", out_valid, m_full);
      chk("m_sel_busy", sel_busy, m_phase != 0);
      chk("m_sel_cur", sel_cur, m_sel);
      chk("m_sel_err", sel_err, m_err);
      acc = in_valid[m_sel] && er != 0;
      if (acc) q.push_back(~in_data[m_sel*8 +: 8]);
      m_err = sel_load && m_phase != 0;
      if (m_phase == 0) begin
        if (sel_load && int'(sel_value) != m_sel) begin m_pend = sel_value; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (!m_full || out_ready) m_phase = 2;
      end else begin
        m_sel = m_pend; m_phase = 0;
      end
      m_full = acc || (m_full && !out_ready);
    end
  end

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_w = q.pop_front();
        chk("sb_out_data", out_data, exp_w);
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sel_cur", sel_cur, 0);
    chk("rst_in_ready", in_ready, 4'b0001);
    // single inverted word on channel 0
    @(posedge clk); #1 in_data[7:0] = 8'hA5; in_valid = 4'b0001; out_ready = 1;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 8'h5A);
    // held output, then select change to channel 2 with a rejected request while busy
    @(posedge clk); #1 in_data[7:0] = 8'h3C; in_valid = 4'b0001; out_ready = 0;
    @(posedge clk); #1 in_valid = 0; sel_load = 1; sel_value = 2;
    @(posedge clk); #1 sel_value = 1;
    @(negedge clk);
    chk("t3_busy", sel_busy, 1);
    chk("t3_in_ready", in_ready, 0);
    @(posedge clk); #1 sel_load = 0;
    @(negedge clk);
    chk("t3_err_pulse", sel_err, 1);
    @(negedge clk);
    chk("t3_err_clear", sel_err, 0);
    chk("t3_held_valid", out_valid, 1);
    chk("t3_held_data", out_data, 8'hC3);
    chk("t3_sel_hold", sel_cur, 0);
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_switch_busy", sel_busy, 1);
    chk("t3_switch_sel", sel_cur, 0);
    @(negedge clk);
    chk("t3_new_sel", sel_cur, 2);
    chk("t3_new_ready", in_ready, 4'b0100);
    chk("t3_busy_fall", sel_busy, 0);
    // async reset in the middle of a drain
    @(posedge clk); #1 in_data[23:16] = 8'h77; in_valid = 4'b0100; out_ready = 0;
    @(posedge clk); #1 in_valid = 0; sel_load = 1; sel_value = 1;
    @(posedge clk); #1 sel_load = 0;
    @(posedge clk); #3 rst = 1;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_busy", sel_busy, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_sel_cur", sel_cur, 0);
    @(posedge clk); #1 rst = 0; out_ready = 1;
    @(negedge clk);
    chk("t5_rel_ready", in_ready, 4'b0001);
    repeat (3) @(negedge clk);
    chk("t5_pending_lost", sel_cur, 0);
    // out-of-range select on the 3-channel, non-inverting instance
    @(posedge clk); #1 sel_load_b = 1; sel_value_b = 3;
    @(posedge clk); #1 sel_load_b = 0;
    @(negedge clk);
    chk("b_err_pulse", sel_err_b, 1);
    chk("b_sel_cur", sel_cur_b, 0);
    chk("b_busy", sel_busy_b, 0);
    @(negedge clk);
    chk("b_err_clear", sel_err_b, 0);
    // back-to-back stream on the non-inverting instance
    out_ready_b = 1;
    fork
      begin : drv
        for (int k = 1; k <= 16; k++) begin
          @(posedge clk); #1 in_data_b[7:0] = 8'(k); in_valid_b = 3'b001;
        end
        @(posedge clk); #1 in_valid_b = 0;
      end
      begin : mon
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid_b && w < 40) begin @(negedge clk); w++; end
        chk("b_stream_start", out_valid_b, 1);
        for (int k = 1; k <= 16; k++) begin
          chk("b_stream_valid", out_valid_b, 1);
          chk("b_stream_data", out_data_b, k);
          @(negedge clk);
        end
      end
    join
    // randomized traffic with random select requests
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      sel_load  = ($urandom_range(0, 7) == 0);
      sel_value = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1 in_valid = 0; sel_load = 0; out_ready = 1;
    repeat (6) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
